// File: rtl/dds_wave_shaper.sv
// Phase address -> offset-binary sample shaper for the DDS chain.
// Three registered stages: shape, amplitude scale, offset/sync. Config commits only at phase wrap or on cfg_now.
module dds_wave_shaper #(
  parameter logic [1:0] WAVE_RESET = 2'd0,
  parameter logic [7:0] AMP_RESET  = 8'd255
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic [1:0] wave_sel,
  input  logic [7:0] amp,
  input  logic       cfg_now,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       sync
);

  logic [1:0]        pend_wave, act_wave, eff_wave;
  logic [7:0]        pend_amp, act_amp, eff_amp;
  logic              prev_msb, wrap, commit;
  logic [6:0]        sine_mag;
  logic signed [7:0] mag_s, s_next;
  logic signed [7:0] s1;
  logic [7:0]        amp1;
  logic              wrap1;
  logic signed [16:0] prod;
  logic signed [7:0] sc2;
  logic              wrap2;
  logic [2:0]        valid_sr;
  logic              unused_prod;

  // Quarter-wave sine, T[i] = round(127*sin(2*pi*(i+0.5)/256)).
  function automatic logic [6:0] sine_q(input logic [5:0] i);
    case (i)
      6'd0:  sine_q = 7'd2;   6'd1:  sine_q = 7'd5;   6'd2:  sine_q = 7'd8;   6'd3:  sine_q = 7'd11;
      6'd4:  sine_q = 7'd14;  6'd5:  sine_q = 7'd17;  6'd6:  sine_q = 7'd20;  6'd7:  sine_q = 7'd23;
      6'd8:  sine_q = 7'd26;  6'd9:  sine_q = 7'd29;  6'd10: sine_q = 7'd32;  6'd11: sine_q = 7'd35;
      6'd12: sine_q = 7'd38;  6'd13: sine_q = 7'd41;  6'd14: sine_q = 7'd44;  6'd15: sine_q = 7'd47;
      6'd16: sine_q = 7'd50;  6'd17: sine_q = 7'd53;  6'd18: sine_q = 7'd56;  6'd19: sine_q = 7'd58;
      6'd20: sine_q = 7'd61;  6'd21: sine_q = 7'd64;  6'd22: sine_q = 7'd67;  6'd23: sine_q = 7'd69;
      6'd24: sine_q = 7'd72;  6'd25: sine_q = 7'd74;  6'd26: sine_q = 7'd77;  6'd27: sine_q = 7'd79;
      6'd28: sine_q = 7'd82;  6'd29: sine_q = 7'd84;  6'd30: sine_q = 7'd86;  6'd31: sine_q = 7'd89;
      6'd32: sine_q = 7'd91;  6'd33: sine_q = 7'd93;  6'd34: sine_q = 7'd95;  6'd35: sine_q = 7'd97;
      6'd36: sine_q = 7'd99;  6'd37: sine_q = 7'd101; 6'd38: sine_q = 7'd103; 6'd39: sine_q = 7'd105;
      6'd40: sine_q = 7'd106; 6'd41: sine_q = 7'd108; 6'd42: sine_q = 7'd110; 6'd43: sine_q = 7'd111;
      6'd44: sine_q = 7'd113; 6'd45: sine_q = 7'd114; 6'd46: sine_q = 7'd115; 6'd47: sine_q = 7'd117;
      6'd48: sine_q = 7'd118; 6'd49: sine_q = 7'd119; 6'd50: sine_q = 7'd120; 6'd51: sine_q = 7'd121;
      6'd52: sine_q = 7'd122; 6'd53: sine_q = 7'd123; 6'd54: sine_q = 7'd124; 6'd55: sine_q = 7'd124;
      6'd56: sine_q = 7'd125; 6'd57: sine_q = 7'd125; 6'd58: sine_q = 7'd126; 6'd59: sine_q = 7'd126;
      default: sine_q = 7'd127;
    endcase
  endfunction

  // The committed config applies to the address of the commit cycle itself.
  assign wrap     = prev_msb & ~addr[7];
  assign commit   = wrap | cfg_now;
  assign eff_wave = commit ? pend_wave : act_wave;
  assign eff_amp  = commit ? pend_amp  : act_amp;

  always_comb begin
    sine_mag = sine_q(addr[6] ? ~addr[5:0] : addr[5:0]);
    mag_s    = {1'b0, sine_mag};
    s_next   = '0;
    case (eff_wave)
      2'd0:    s_next = addr[7] ? -mag_s : mag_s;
      2'd1:    s_next = addr[7] ? -8'sd127 : 8'sd127;
      2'd2:    s_next = addr[7] ? $signed(8'd127 - {addr[6:0], 1'b0})
                                : $signed({~addr[6], addr[5:0], 1'b0});
      default: s_next = $signed({~addr[7], addr[6:0]});
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pend_wave <= WAVE_RESET;
      pend_amp  <= AMP_RESET;
      act_wave  <= WAVE_RESET;
      act_amp   <= AMP_RESET;
      prev_msb  <= 1'b0;
    end else begin
      pend_wave <= wave_sel;
      pend_amp  <= amp;
      act_wave  <= eff_wave;
      act_amp   <= eff_amp;
      prev_msb  <= addr[7];
    end
  end

  // Unsigned amplitude is zero-extended so the product stays signed; floor shift keeps -128..126.
  assign prod        = s1 * $signed({1'b0, amp1});
  assign unused_prod = ^{prod[16], prod[7:0]};
  assign dout_valid  = valid_sr[2];

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      amp1     <= '0;
      wrap1    <= 1'b0;
      sc2      <= '0;
      wrap2    <= 1'b0;
      dout     <= 8'h80;
      sync     <= 1'b0;
      valid_sr <= '0;
    end else begin
      s1       <= s_next;
      amp1     <= eff_amp;
      wrap1    <= wrap;
      sc2      <= prod[15:8];
      wrap2    <= wrap1;
      dout     <= {~sc2[7], sc2[6:0]};
      sync     <= wrap2;
      valid_sr <= {valid_sr[1:0], 1'b1};
    end
  end

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Bench for dds_wave_shaper: arithmetic reference model with staged-commit rules, per-cycle compare, literal pins.
module tb_dds_wave_shaper;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [1:0] wave_sel = 2'd0;
  logic [7:0] amp = 8'd255;
  logic       cfg_now = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       sync;

  dds_wave_shaper dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .addr(addr), .wave_sel(wave_sel),
    .amp(amp), .cfg_now(cfg_now), .dout(dout), .dout_valid(dout_valid), .sync(sync)
  );

  always #10 clk_50M = ~clk_50M;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int sin_t[64];

  function automatic int shape(input int a, input int w);
    int q, i;
    q = a / 64;
    i = a % 64;
    case (w)
      0: begin
        if (q == 0)      shape = sin_t[i];
        else if (q == 1) shape = sin_t[63 - i];
        else if (q == 2) shape = -sin_t[i];
        else             shape = -sin_t[63 - i];
      end
      1:       shape = (a < 128) ? 127 : -127;
      2:       shape = (a < 128) ? 2 * a - 128 : 383 - 2 * a;
      default: shape = a - 128;
    endcase
  endfunction

  function automatic int expect_dout(input int a, input int w, input int am);
    int v;
    v = shape(a, w) * am;
    expect_dout = $rtoi($floor(real'(v) / 256.0)) + 128;
  endfunction

  // Entry: {pin_sync_en, pin_sync, pin_dout_en, pin_dout[7:0], sync, dout[7:0]}
  logic [19:0] exp_q[$];
  logic [19:0] exp_ent = {11'd0, 1'b0, 8'h80};
  logic        exp_valid = 1'b0;
  int m_prev_msb = 0, m_pend_w = 0, m_pend_a = 255, m_act_w = 0, m_act_a = 255;
  int m_wrap, m_smp;

  logic       pin_en = 1'b0, pin_sen = 1'b0, pin_sync = 1'b0;
  logic [7:0] pin_dout = 8'd0;

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_msb = 0;
      m_pend_w = 0;   m_pend_a = 255;
      m_act_w = 0;    m_act_a = 255;
      exp_q.delete();
      exp_ent = {11'd0, 1'b0, 8'h80};
      exp_valid = 1'b0;
    end else begin
      m_wrap = (m_prev_msb == 1 && addr[7] == 1'b0) ? 1 : 0;
      if (m_wrap == 1 || cfg_now) begin
        m_act_w = m_pend_w;
        m_act_a = m_pend_a;
      end
      m_smp = expect_dout(int'(addr), m_act_w, m_act_a);
      exp_q.push_back({pin_sen, pin_sync, pin_en, pin_dout, 1'(m_wrap), 8'(m_smp)});
      m_pend_w = int'(wave_sel);
      m_pend_a = int'(amp);
      m_prev_msb = int'(addr[7]);
      if (exp_q.size() == 3) begin
        exp_ent = exp_q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_ent = {11'd0, 1'b0, 8'h80};
      end
    end
  end

  // ---------------- compare, every cycle ----------------
  always @(negedge clk_50M) begin
    chk("dout", int'(dout), int'(exp_ent[7:0]));
    chk("dout_valid", int'(dout_valid), int'(exp_valid));
    chk("sync", int'(sync), int'(exp_ent[8]));
    if (exp_ent[17]) chk("pin_dout", int'(dout), int'(exp_ent[16:9]));
    if (exp_ent[19]) chk("pin_sync", int'(sync), int'(exp_ent[18]));
  end

  // ---------------- driver ----------------
  task automatic drive(input int a, input int w, input int am, input bit cfg,
                       input int pd = -1, input int ps = -1);
    @(posedge clk_50M);
    #1;
    addr = 8'(a);
    wave_sel = 2'(w);
    amp = 8'(am);
    cfg_now = cfg;
    pin_en = (pd >= 0);
    pin_dout = 8'(pd);
    pin_sen = (ps >= 0);
    pin_sync = ps[0];
  endtask

  int ra, step;

  initial begin
    for (int i = 0; i < 64; i++)
      sin_t[i] = $rtoi(127.0 * $sin(2.0 * 3.14159265358979 * (real'(i) + 0.5) / 256.0) + 0.5);

    repeat (3) @(posedge clk_50M);
    #1 rst_n = 1'b1;

    // Sine at reset amplitude
    drive(0, 0, 255, 0, 129);
    drive(64, 0, 255, 0, 254);
    drive(192, 0, 255, 0, 1);
    drive(192, 0, 255, 0);

    // Square at amp 128
    drive(5, 1, 128, 0);
    drive(200, 1, 128, 1, 64);
    drive(10, 1, 128, 0, 191, 1);

    // Staged commit across a full ramp
    drive(50, 0, 128, 0);
    drive(60, 0, 128, 1);
    for (int a = 0; a < 256; a++) begin
      if (a == 0)        drive(a, 0, 128, 0, 129, 0);
      else if (a == 101) drive(a, 1, 128, 0, 166, 0);
      else if (a == 255) drive(a, 1, 128, 0, 127, 0);
      else               drive(a, (a >= 100) ? 1 : 0, 128, 0);
    end
    drive(0, 1, 128, 0, 191, 1);
    drive(1, 1, 128, 0, 191, 0);

    // cfg_now forcing amp 0 without a wrap
    for (int a = 30; a < 39; a++) drive(a, 1, 128, 0);
    drive(39, 1, 0, 0);
    drive(40, 1, 0, 1, 128, 0);
    for (int a = 41; a <= 50; a++) drive(a, 1, 0, 0, 128, 0);

    // Triangle and sawtooth endpoints
    drive(50, 2, 255, 0);
    drive(128, 2, 255, 1, 254);
    drive(0, 2, 255, 0, 0, 1);
    drive(10, 3, 255, 0);
    drive(255, 3, 255, 1, 254);
    drive(0, 3, 255, 0, 0, 1);

    // Randomized sweep with jumps, config churn and occasional cfg_now
    ra = 0;
    step = $urandom_range(1, 40);
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 255);
      else ra = (ra + step) % 256;
      if ($urandom_range(0, 63) == 0) step = $urandom_range(1, 200);
      drive(ra, $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 255) : $urandom_range(0, 255),
            ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges
    @(posedge clk_50M);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dout", int'(dout), 128);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_sync", int'(sync), 0);
    repeat (2) @(posedge clk_50M);
    #1;
    rst_n = 1'b1;
    addr = 8'd64; wave_sel = 2'd2; amp = 8'd10; cfg_now = 1'b0;
    pin_en = 1'b1; pin_dout = 8'd254; pin_sen = 1'b1; pin_sync = 1'b0;
    drive(65, 2, 10, 0, 254);
    drive(66, 2, 10, 0);
    repeat (6) drive(70, 2, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
